// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, hold buffer and redirect/kill handling
// Owns the PC, runs the imem req/ready handshake and feeds decode through the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_PC,
  input  logic        write_IFID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IFID,
  output logic [31:0] pcPlus4_IFID,
  output logic        valid_IFID
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetchState;

  fetchState   state;
  fetchState   stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] killAddr;
  logic [31:0] killAddrNext;
  logic [31:0] bufInstr;
  logic [31:0] bufInstrNext;
  logic [31:0] bufPcPlus4;
  logic [31:0] bufPcPlus4Next;
  logic [31:0] instrNext;
  logic [31:0] pcPlus4Next;
  logic        validNext;
  logic [31:0] pcInc;
  logic        accept;
  logic        advance;

  assign pcInc     = pc + 32'd4;
  assign imem_req  = !reset && (state != HOLD);
  // While killing, the abandoned address must stay on the bus until imem accepts it.
  assign imem_addr = (state == KILL) ? killAddr : pc;
  assign accept    = imem_req & imem_ready;
  assign advance   = write_IFID & write_PC;

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    killAddrNext   = killAddr;
    bufInstrNext   = bufInstr;
    bufPcPlus4Next = bufPcPlus4;
    instrNext      = instruction_IFID;
    pcPlus4Next    = pcPlus4_IFID;
    validNext      = valid_IFID;

    // Any cycle where IF/ID may load but gets no real word turns into a bubble.
    if (write_IFID) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end

    if (branch_taken) begin
      pcNext         = branch_target;
      instrNext      = NOP_INSTR;
      validNext      = 1'b0;
      bufInstrNext   = NOP_INSTR;
      bufPcPlus4Next = 32'd0;
    end

    case (state)
      FETCH: begin
        if (branch_taken) begin
          if (!accept) begin
            stateNext    = KILL;
            killAddrNext = pc;
          end
        end else if (accept) begin
          if (advance) begin
            instrNext   = imem_rdata;
            pcPlus4Next = pcInc;
            validNext   = 1'b1;
            pcNext      = pcInc;
          end else begin
            bufInstrNext   = imem_rdata;
            bufPcPlus4Next = pcInc;
            stateNext      = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          stateNext = FETCH;
        end else if (advance) begin
          instrNext   = bufInstr;
          pcPlus4Next = bufPcPlus4;
          validNext   = 1'b1;
          pcNext      = pcInc;
          stateNext   = FETCH;
        end
      end
      KILL: begin
        if (accept) begin
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      killAddr         <= RESET_PC;
      bufInstr         <= NOP_INSTR;
      bufPcPlus4       <= 32'd0;
      instruction_IFID <= NOP_INSTR;
      pcPlus4_IFID     <= 32'd0;
      valid_IFID       <= 1'b0;
    end else begin
      state            <= stateNext;
      pc               <= pcNext;
      killAddr         <= killAddrNext;
      bufInstr         <= bufInstrNext;
      bufPcPlus4       <= bufPcPlus4Next;
      instruction_IFID <= instrNext;
      pcPlus4_IFID     <= pcPlus4Next;
      valid_IFID       <= validNext;
    end
  end

endmodule
